vga_top: RTL and testbench



---
 rtl/vga_top.sv | 93 +++++++++
 tb/tb_vga_top.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_top.sv
// VGA 640x480@60 test-pattern source: 25 MHz pixel enable from a 50 MHz clock,
// H/V timing counters, registered sync/colour-bar decode and a frame counter on the LEDs.
module vga_top #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int BAR_WIDTH = 80
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  output logic        VGA_HS_o,
  output logic        VGA_VS_o,
  output logic [11:0] RGB_o,
  output logic [11:0] LED_o
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS = HW'(H_VISIBLE);
  localparam logic [VW-1:0] V_VIS = VW'(V_VISIBLE);
  localparam logic [HW-1:0] HS_LO = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_HI = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_LO = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_HI = VW'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [HW-1:0] BAR_W = HW'(BAR_WIDTH);

  logic          div;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [11:0]   frame_cnt;
  logic          h_last, v_last;

  assign h_last = (hcnt == H_MAX);
  assign v_last = (vcnt == V_MAX);

  // div doubles as the pixel enable: counters advance on every second clk
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      div       <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
      frame_cnt <= '0;
    end else begin
      div <= ~div;
      if (div) begin
        hcnt <= h_last ? '0 : hcnt + HW'(1);
        if (h_last) begin
          vcnt <= v_last ? '0 : vcnt + VW'(1);
          if (v_last) frame_cnt <= frame_cnt + 12'd1;
        end
      end
    end
  end

  logic          hs_d, vs_d;
  logic [HW-1:0] bar;
  logic [2:0]    idx;
  logic [11:0]   rgb_d;

  always_comb begin
    hs_d  = !((hcnt >= HS_LO) && (hcnt <= HS_HI));
    vs_d  = !((vcnt >= VS_LO) && (vcnt <= VS_HI));
    bar   = hcnt / BAR_W;
    idx   = 3'(32'd7 - 32'(bar));
    rgb_d = '0;
    if ((hcnt < H_VIS) && (vcnt < V_VIS))
      rgb_d = {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
  end

  // one register stage on all decoded outputs keeps them mutually aligned
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      VGA_HS_o <= 1'b1;
      VGA_VS_o <= 1'b1;
      RGB_o    <= '0;
    end else begin
      VGA_HS_o <= hs_d;
      VGA_VS_o <= vs_d;
      RGB_o    <= rgb_d;
    end
  end

  assign LED_o = frame_cnt;
endmodule

// File: tb/tb_vga_top.sv
// Bench for vga_top: full horizontal timing with a shortened frame, plus a tiny-raster
// instance that reaches the 12-bit LED wrap in a few tens of thousands of clocks.
module tb_vga_top;
  localparam int HV = 640, HF = 16, HSY = 96, HB = 48;
  localparam int VV = 4, VF = 1, VSY = 2, VB = 1, BW = 80;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FR = 2 * HT * VT;    // frame period in clks
  localparam int FR2_PIX = 4;         // small instance: 2x2 raster

  logic clk = 1'b0, arstn = 1'b0;
  logic hs, vs, hs2, vs2;
  logic [11:0] rgb, led, rgb2, led2;
  int k = 0;
  int checks = 0, failures = 0;

  vga_top #(.V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)) dut (
    .clk_i(clk), .arstn_i(arstn), .VGA_HS_o(hs), .VGA_VS_o(vs), .RGB_o(rgb), .LED_o(led));

  vga_top #(.H_VISIBLE(1), .H_FP(0), .H_SYNC(1), .H_BP(0), .V_VISIBLE(1), .V_FP(0),
            .V_SYNC(1), .V_BP(0), .BAR_WIDTH(1)) dut2 (
    .clk_i(clk), .arstn_i(arstn), .VGA_HS_o(hs2), .VGA_VS_o(vs2), .RGB_o(rgb2), .LED_o(led2));

  always #10 clk = ~clk;

  // Reference: after k rising edges since release, outputs show pixel (k-1)/2
  function automatic logic [11:0] m_rgb(int kk);
    int p, h, v;
    if (kk < 1) return 12'h000;
    p = (kk - 1) / 2; h = p % HT; v = (p / HT) % VT;
    if (h >= HV || v >= VV) return 12'h000;
    case (h / BW)
      0: return 12'hFFF; 1: return 12'hFF0; 2: return 12'hF0F; 3: return 12'hF00;
      4: return 12'h0FF; 5: return 12'h0F0; 6: return 12'h00F; default: return 12'h000;
    endcase
  endfunction

  function automatic logic m_hs(int kk);
    int h;
    if (kk < 1) return 1'b1;
    h = ((kk - 1) / 2) % HT;
    return !(h >= HV + HF && h < HV + HF + HSY);
  endfunction

  function automatic logic m_vs(int kk);
    int v;
    if (kk < 1) return 1'b1;
    v = (((kk - 1) / 2) / HT) % VT;
    return !(v >= VV + VF && v < VV + VF + VSY);
  endfunction

  function automatic logic [11:0] m_led(int kk, int frame_pix);
    return 12'(((kk / 2) / frame_pix) % 4096);
  endfunction

  task automatic step();
    @(posedge clk); k++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (hs !== 1'b1 || vs !== 1'b1 || rgb !== 12'h000 || led !== 12'h000) begin
        failures++;
        $display("FAIL reset_hold: hs=%b vs=%b rgb=%h led=%h, required 1 1 000 000", hs, vs, rgb, led);
      end
    end
    arstn = 1'b1; k = 0;
  endtask

  task automatic test_rgb_line0();
    int px[6] = '{0, 80, 240, 560, 639, 640};
    logic [11:0] ex[6] = '{12'hFFF, 12'hFF0, 12'hF00, 12'h000, 12'h000, 12'h000};
    for (int i = 0; i < 6; i++) begin
      while (k < 2 * px[i] + 1) step();
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (rgb !== ex[i]) begin
          failures++;
          $display("FAIL rgb_px%0d: got %h, required %h (k=%0d)", px[i], rgb, ex[i], k);
        end
        step();
      end
    end
  endtask

  task automatic test_hsync();
    int falls[$], rises[$];
    logic phs = hs;
    int n = 0;
    while (rises.size() < 3 && n < 6000) begin
      step(); n++;
      checks++;
      if (hs !== m_hs(k)) begin
        failures++;
        $display("FAIL hs_model: got %b, required %b (k=%0d)", hs, m_hs(k), k);
      end
      if (phs && !hs) falls.push_back(k);
      if (!phs && hs && falls.size() > 0) rises.push_back(k);
      phs = hs;
    end
    checks++;
    if (rises.size() < 3 || falls.size() < 3) begin
      failures++;
      $display("FAIL hs_edges: got %0d falls %0d rises, required 3 each", falls.size(), rises.size());
    end else begin
      checks++;
      if (falls[0] != 2 * (HV + HF) + 1) begin
        failures++;
        $display("FAIL hs_first_fall: got k=%0d, required %0d", falls[0], 2 * (HV + HF) + 1);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rises[i] - falls[i] != 2 * HSY) begin
          failures++;
          $display("FAIL hs_width: got %0d clks, required %0d", rises[i] - falls[i], 2 * HSY);
        end
        if (i > 0) begin
          checks++;
          if (falls[i] - falls[i-1] != 2 * HT) begin
            failures++;
            $display("FAIL hs_period: got %0d clks, required %0d", falls[i] - falls[i-1], 2 * HT);
          end
        end
      end
    end
  endtask

  task automatic test_frames();
    int vs_f[$], vs_r[$], led_k[$];
    logic [11:0] led_v[$];
    int hs_in_vs = 0;
    logic pvs = vs, phs = hs;
    logic [11:0] pled = led;
    while (k < 3 * FR + 2) begin
      step();
      checks++;
      if (hs !== m_hs(k) || vs !== m_vs(k) || rgb !== m_rgb(k) || led !== m_led(k, HT * VT)) begin
        failures++;
        $display("FAIL frame_model: got hs=%b vs=%b rgb=%h led=%h, required %b %b %h %h (k=%0d)",
                 hs, vs, rgb, led, m_hs(k), m_vs(k), m_rgb(k), m_led(k, HT * VT), k);
      end
      checks++;
      if (led2 !== m_led(k, FR2_PIX)) begin
        failures++;
        $display("FAIL led2_model: got %h, required %h (k=%0d)", led2, m_led(k, FR2_PIX), k);
      end
      if (k == 32767 || k == 32768) begin
        checks++;
        if (led2 !== ((k == 32767) ? 12'hFFF : 12'h000)) begin
          failures++;
          $display("FAIL led_wrap: got %h at k=%0d", led2, k);
        end
      end
      if (((k - 1) / 2) % HT == 100 && (((k - 1) / 2) / HT) % VT == VV) begin
        checks++;
        if (rgb !== 12'h000) begin
          failures++;
          $display("FAIL rgb_vblank: got %h, required 000", rgb);
        end
      end
      if (pvs && !vs) vs_f.push_back(k);
      if (!pvs && vs && vs_f.size() > 0) vs_r.push_back(k);
      if (!vs && phs && !hs && vs_f.size() == 1 && vs_r.size() == 0) hs_in_vs++;
      if (led !== pled) begin led_k.push_back(k); led_v.push_back(led); end
      pvs = vs; phs = hs; pled = led;
    end
    checks++;
    if (vs_f.size() != 3 || vs_r.size() < 2) begin
      failures++;
      $display("FAIL vs_edges: got %0d falls %0d rises, required 3 and >=2", vs_f.size(), vs_r.size());
    end else begin
      checks++;
      if (vs_f[1] - vs_f[0] != FR || vs_f[2] - vs_f[1] != FR) begin
        failures++;
        $display("FAIL vs_period: got %0d,%0d clks, required %0d", vs_f[1] - vs_f[0], vs_f[2] - vs_f[1], FR);
      end
      checks++;
      if (vs_r[0] - vs_f[0] != 2 * HT * VSY) begin
        failures++;
        $display("FAIL vs_width: got %0d clks, required %0d", vs_r[0] - vs_f[0], 2 * HT * VSY);
      end
    end
    checks++;
    if (hs_in_vs != VSY) begin
      failures++;
      $display("FAIL hs_during_vs: got %0d falls, required %0d", hs_in_vs, VSY);
    end
    checks++;
    if (led_k.size() != 3) begin
      failures++;
      $display("FAIL led_changes: got %0d, required 3", led_k.size());
    end else
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (led_k[i] != (i + 1) * FR || led_v[i] !== 12'(i + 1)) begin
          failures++;
          $display("FAIL led_step%0d: got %h at k=%0d, required %h at k=%0d",
                   i, led_v[i], led_k[i], 12'(i + 1), (i + 1) * FR);
        end
      end
  endtask

  task automatic test_midframe_reset();
    for (int it = 0; it < 2; it++) begin
      int run = $urandom_range(200, 3000);
      for (int i = 0; i < run; i++) step();
      #($urandom_range(1, 8));
      arstn = 1'b0;
      #1;
      checks++;
      if (hs !== 1'b1 || vs !== 1'b1 || rgb !== 12'h000 || led !== 12'h000) begin
        failures++;
        $display("FAIL async_reset: hs=%b vs=%b rgb=%h led=%h, required 1 1 000 000", hs, vs, rgb, led);
      end
      for (int i = 0; i < 3; i++) step();
      arstn = 1'b1; k = 0;
      run = $urandom_range(1500, 4000);
      for (int i = 0; i < run; i++) begin
        step();
        checks++;
        if (hs !== m_hs(k) || vs !== m_vs(k) || rgb !== m_rgb(k) || led !== m_led(k, HT * VT)) begin
          failures++;
          $display("FAIL restart_model: got hs=%b vs=%b rgb=%h led=%h, required %b %b %h %h (k=%0d)",
                   hs, vs, rgb, led, m_hs(k), m_vs(k), m_rgb(k), m_led(k, HT * VT), k);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rgb_line0();
    test_hsync();
    test_frames();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
